// File: rtl/sort4_pkg.sv
// Shared encodings and frame constants for the serial four-word sorter.
package sort4_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_SORT = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   localparam logic MODE_ASC  = 1'b0;
   localparam logic MODE_DESC = 1'b1;

   localparam int FRAME_LEN  = 4;
   localparam int SORT_STEPS = 5;

endpackage

// File: rtl/sort4_stream_cmp.sv
// Two-input unsigned compare-exchange cell: presents the smaller and larger word.
module sort4_stream_cmp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_min,
   output logic [WIDTH-1:0] o_max
);

   logic w_aGtB;

   assign w_aGtB = (i_a > i_b);
   assign o_min  = w_aGtB ? i_b : i_a;
   assign o_max  = w_aGtB ? i_a : i_b;

endmodule

// File: rtl/sort4_stream.sv
// Serial four-word sorter: load four beats, run a five-step compare-exchange
// network through one shared comparator, then stream the frame back out.
module sort4_stream
   import sort4_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam logic [2:0] LAST_BEAT = 3'(FRAME_LEN - 1);
   localparam logic [2:0] LAST_STEP = 3'(SORT_STEPS - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_word [FRAME_LEN];
   logic [2:0]       r_cnt;
   logic             r_mode;

   logic [1:0]       w_idxA;
   logic [1:0]       w_idxB;
   logic [1:0]       w_sendIdx;
   logic [WIDTH-1:0] w_min;
   logic [WIDTH-1:0] w_max;

   // Odd-even merge network for four words, one pair per SORT step.
   always_comb begin
      w_idxA = 2'd0;
      w_idxB = 2'd1;
      case (r_cnt)
         3'd0: begin w_idxA = 2'd0; w_idxB = 2'd1; end
         3'd1: begin w_idxA = 2'd2; w_idxB = 2'd3; end
         3'd2: begin w_idxA = 2'd0; w_idxB = 2'd2; end
         3'd3: begin w_idxA = 2'd1; w_idxB = 2'd3; end
         3'd4: begin w_idxA = 2'd1; w_idxB = 2'd2; end
         default: begin w_idxA = 2'd0; w_idxB = 2'd1; end
      endcase
   end

   sort4_stream_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .i_a   (r_word[w_idxA]),
      .i_b   (r_word[w_idxB]),
      .o_min (w_min),
      .o_max (w_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   assign w_sendIdx = (r_mode == MODE_DESC) ? (2'd3 - r_cnt[1:0]) : r_cnt[1:0];

   // Handshake outputs come from state alone so no ready/valid path loops back.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_data    = '0;
      busy        = 1'b0;
      case (r_state)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_cnt == LAST_BEAT)) begin
               w_nextState = ST_SORT;
            end
         end
         ST_SORT: begin
            busy = 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_nextState = ST_SEND;
            end
         end
         ST_SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = r_word[w_sendIdx];
            out_last  = (r_cnt == LAST_BEAT);
            if (out_ready && (r_cnt == LAST_BEAT)) begin
               w_nextState = ST_LOAD;
            end
         end
         default: begin
            w_nextState = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FRAME_LEN; k++) begin
            r_word[k] <= '0;
         end
         r_cnt  <= 3'd0;
         r_mode <= MODE_ASC;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (in_valid) begin
                  r_word[r_cnt[1:0]] <= in_data;
                  if (r_cnt == 3'd0) begin
                     r_mode <= in_mode;
                  end
                  r_cnt <= (r_cnt == LAST_BEAT) ? 3'd0 : r_cnt + 3'd1;
               end
            end
            ST_SORT: begin
               r_word[w_idxA] <= w_min;
               r_word[w_idxB] <= w_max;
               r_cnt          <= (r_cnt == LAST_STEP) ? 3'd0 : r_cnt + 3'd1;
            end
            ST_SEND: begin
               if (out_ready) begin
                  r_cnt <= (r_cnt == LAST_BEAT) ? 3'd0 : r_cnt + 3'd1;
               end
            end
            default: begin
               r_cnt <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort4_stream.sv
// Directed and random self-checking bench for sort4_stream.
module tb_sort4_stream;

   localparam int WIDTH = 4;

   typedef logic [3:0][WIDTH-1:0] frame_t;

   typedef struct {
      frame_t      din;
      logic        mode;
      bit          flipMode;
      int          gapCycles;
      logic [15:0] readyPat;
      int          patLen;
      frame_t      expd;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_mode = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_last;
   logic             busy;

   int testsRun = 0;
   int testsFailed = 0;
   int frameId = 0;

   sort4_stream #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL frame %0d %s: got %0d, expected %0d", frameId, name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic frame_t pack4(input int a, input int b, input int c, input int d);
      frame_t f;
      f[0] = WIDTH'(a);
      f[1] = WIDTH'(b);
      f[2] = WIDTH'(c);
      f[3] = WIDTH'(d);
      return f;
   endfunction

   function automatic frame_t refSort(input frame_t din, input logic mode);
      frame_t f;
      logic [WIDTH-1:0] t;
      f = din;
      for (int p = 0; p < 3; p++) begin
         for (int q = 0; q < 3 - p; q++) begin
            if (f[q] > f[q+1]) begin
               t = f[q];
               f[q] = f[q+1];
               f[q+1] = t;
            end
         end
      end
      if (mode) begin
         return pack4(int'(f[3]), int'(f[2]), int'(f[1]), int'(f[0]));
      end
      return f;
   endfunction

   // Offers four beats back to back, optionally pausing after the second.
   task automatic applyStimulus(input frame_t din, input logic mode, input bit flipMode,
                                input int gapCycles);
      for (int b = 0; b < 4; b++) begin
         int guard;
         guard = 0;
         in_data  = din[b];
         in_mode  = (flipMode && b > 0) ? ~mode : mode;
         in_valid = 1'b1;
         while (!in_ready && guard < 100) begin
            tick();
            guard++;
         end
         if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         tick();
         in_valid = 1'b0;
         if (b == 1) begin
            for (int g = 0; g < gapCycles; g++) begin
               checkOutput("gap_in_ready", int'(in_ready), 1);
               checkOutput("gap_busy", int'(busy), 0);
               tick();
            end
         end
      end
   endtask

   // Drains one frame, checking every presented word, including stalled cycles.
   task automatic collectFrame(input frame_t expd, input int latencyExp,
                               input logic [15:0] readyPat, input int patLen,
                               input bit randStall);
      int n;
      int k;
      int c;
      logic rdy;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         checkOutput("out_valid_timeout", 0, 1);
         return;
      end
      if (latencyExp >= 0) begin
         checkOutput("latency", n, latencyExp);
      end
      in_valid = 1'b1;
      in_data  = 4'hA;
      k = 0;
      c = 0;
      while (k < 4 && c < 200) begin
         if (randStall) begin
            rdy = ($urandom_range(0, 2) != 0);
         end else if (c < patLen) begin
            rdy = readyPat[c];
         end else begin
            rdy = 1'b1;
         end
         out_ready = rdy;
         checkOutput("out_valid", int'(out_valid), 1);
         checkOutput("out_data", int'(out_data), int'(expd[k]));
         checkOutput("out_last", int'(out_last), (k == 3) ? 1 : 0);
         checkOutput("in_ready_send", int'(in_ready), 0);
         tick();
         if (rdy) begin
            k++;
         end
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("handshakes", k, 4);
      checkOutput("drained_out_valid", int'(out_valid), 0);
      checkOutput("drained_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      vec_t vecs[8];
      frame_t rf;
      logic rm;

      vecs[0] = '{pack4(9, 3, 12, 3),  1'b0, 1'b0, 0, 16'h0000, 0, pack4(3, 3, 9, 12)};
      vecs[1] = '{pack4(1, 15, 0, 7),  1'b1, 1'b1, 0, 16'h0000, 0, pack4(15, 7, 1, 0)};
      vecs[2] = '{pack4(2, 5, 8, 11),  1'b0, 1'b0, 0, 16'h0069, 7, pack4(2, 5, 8, 11)};
      vecs[3] = '{pack4(4, 4, 4, 4),   1'b0, 1'b0, 3, 16'h0000, 0, pack4(4, 4, 4, 4)};
      vecs[4] = '{pack4(10, 0, 5, 1),  1'b0, 1'b0, 0, 16'h0000, 0, pack4(0, 1, 5, 10)};
      vecs[5] = '{pack4(15, 15, 0, 0), 1'b1, 1'b0, 0, 16'h0000, 0, pack4(15, 15, 0, 0)};
      vecs[6] = '{pack4(5, 6, 7, 8),   1'b1, 1'b1, 0, 16'h0000, 0, pack4(8, 7, 6, 5)};
      vecs[7] = '{pack4(15, 0, 15, 0), 1'b0, 1'b0, 0, 16'h0005, 4, pack4(0, 0, 15, 15)};

      rst_n = 1'b0;
      tick();
      tick();
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_out_last", int'(out_last), 0);
      checkOutput("reset_out_data", int'(out_data), 0);
      checkOutput("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 8; v++) begin
         frameId = v;
         applyStimulus(vecs[v].din, vecs[v].mode, vecs[v].flipMode, vecs[v].gapCycles);
         collectFrame(vecs[v].expd, 5, vecs[v].readyPat, vecs[v].patLen, 1'b0);
      end

      // Reset during SORT step 2.
      frameId = 100;
      applyStimulus(pack4(13, 7, 1, 3), 1'b0, 1'b0, 0);
      tick();
      tick();
      checkOutput("sort_busy", int'(busy), 1);
      checkOutput("sort_out_valid", int'(out_valid), 0);
      checkOutput("sort_in_ready", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_sort_out_valid", int'(out_valid), 0);
      checkOutput("rst_sort_in_ready", int'(in_ready), 1);
      checkOutput("rst_sort_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_sort_out_valid", int'(out_valid), 0);

      // Reset after two SEND handshakes.
      frameId = 101;
      applyStimulus(pack4(3, 14, 8, 2), 1'b1, 1'b0, 0);
      for (int w = 0; w < 20 && !out_valid; w++) begin
         tick();
      end
      checkOutput("send_out_valid", int'(out_valid), 1);
      checkOutput("send_first_word", int'(out_data), 14);
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      checkOutput("send_third_word", int'(out_data), 3);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_send_out_valid", int'(out_valid), 0);
      checkOutput("rst_send_in_ready", int'(in_ready), 1);
      checkOutput("rst_send_out_data", int'(out_data), 0);
      checkOutput("rst_send_out_last", int'(out_last), 0);
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("post_rst_send_out_valid", int'(out_valid), 0);

      frameId = 102;
      applyStimulus(pack4(6, 2, 9, 1), 1'b0, 1'b0, 0);
      collectFrame(pack4(1, 2, 6, 9), 5, 16'h0000, 0, 1'b0);

      for (int r = 0; r < 1000; r++) begin
         frameId = 1000 + r;
         rf = pack4($urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15));
         rm = 1'($urandom_range(0, 1));
         applyStimulus(rf, rm, 1'($urandom_range(0, 1)), 0);
         collectFrame(refSort(rf, rm), 5, 16'h0000, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
